// File: rtl/sap_core_param.sv
// Parametrised SAP-style multicycle accumulator core with an internal RAM.
// The RAM is loaded through the program port while stopped; results leave via a valid-qualified output register.
module sap_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              running,
  output logic [ADDR_W-1:0] dbg_pc
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned OP_W  = 4;

  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_STOP,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [ADDR_W-1:0] mar, mar_d;
  logic [OP_W-1:0]   ir_op, ir_op_d;
  logic [ADDR_W-1:0] ir_arg, ir_arg_d;
  logic [DATA_W-1:0] a, a_d;
  logic [DATA_W-1:0] b, b_d;
  logic              cf, cf_d;
  logic              zf, zf_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic              halted_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              alu_sub;
  logic [DATA_W:0]   alu_sum;

  // Register-array RAM: combinational read at MAR, synchronous write
  assign ram_rd = mem[mar];

  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // SUB is A + ~B + 1, so the carry out reads as "no borrow"
  assign alu_sub = (ir_op == OP_SUB);
  assign alu_sum = {1'b0, a} + {1'b0, b ^ {DATA_W{alu_sub}}} + {{DATA_W{1'b0}}, alu_sub};

  assign dbg_pc = pc;

  // Control sequencer: next state, datapath loads and RAM write select
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    mar_d       = mar;
    ir_op_d     = ir_op;
    ir_arg_d    = ir_arg;
    a_d         = a;
    b_d         = b;
    cf_d        = cf;
    zf_d        = zf;
    out_data_d  = out_data;
    out_valid_d = 1'b0;
    halted_d    = halted;
    ram_we      = 1'b0;
    ram_waddr   = prog_addr;
    ram_wdata   = prog_data;

    unique case (state)
      ST_STOP: begin
        ram_we = prog_we;
        if (run) begin
          pc_d     = '0;
          halted_d = 1'b0;
          state_d  = ST_T1;
        end
      end
      ST_T1: begin
        mar_d   = pc;
        state_d = ST_T2;
      end
      ST_T2: begin
        ir_op_d  = ram_rd[DATA_W-1 -: OP_W];
        ir_arg_d = ram_rd[ADDR_W-1:0];
        pc_d     = pc + ADDR_W'(1);
        state_d  = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T1;
        case (ir_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = ir_arg;
            state_d = ST_T4;
          end
          OP_LDI: a_d = DATA_W'(ir_arg);
          OP_JMP: pc_d = ir_arg;
          OP_JC:  if (cf) pc_d = ir_arg;
          OP_JZ:  if (zf) pc_d = ir_arg;
          OP_OUT: begin
            out_data_d  = a;
            out_valid_d = 1'b1;
          end
          OP_HLT: begin
            halted_d = 1'b1;
            state_d  = ST_STOP;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        state_d = ST_T1;
        case (ir_op)
          OP_LDA: a_d = ram_rd;
          OP_ADD, OP_SUB: begin
            b_d     = ram_rd;
            state_d = ST_T5;
          end
          OP_STA: begin
            ram_we    = 1'b1;
            ram_waddr = mar;
            ram_wdata = a;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        a_d     = alu_sum[DATA_W-1:0];
        cf_d    = alu_sum[DATA_W];
        zf_d    = (alu_sum[DATA_W-1:0] == '0);
        state_d = ST_T1;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_STOP;
      pc        <= '0;
      mar       <= '0;
      ir_op     <= '0;
      ir_arg    <= '0;
      a         <= '0;
      b         <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      mar       <= mar_d;
      ir_op     <= ir_op_d;
      ir_arg    <= ir_arg_d;
      a         <= a_d;
      b         <= b_d;
      cf        <= cf_d;
      zf        <= zf_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      halted    <= halted_d;
      running   <= (state_d != ST_STOP);
    end
  end

endmodule

// File: tb/tb_sap_core_param.sv
// Self-checking bench for sap_core_param: directed programs plus random programs
// compared against an instruction-level interpreter with per-instruction cycle costs.
module tb_sap_core_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic       running;
  logic [3:0] dbg_pc;

  logic        w_run;
  logic        w_prog_we;
  logic [7:0]  w_prog_addr;
  logic [11:0] w_prog_data;
  logic [11:0] w_out_data;
  logic        w_out_valid;
  logic        w_halted;
  logic        w_running;
  logic [7:0]  w_dbg_pc;

  always #5 clk = ~clk;

  sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_data(out_data), .out_valid(out_valid),
    .halted(halted), .running(running), .dbg_pc(dbg_pc)
  );

  sap_core_param #(.DATA_W(12), .ADDR_W(8)) dut_w (
    .clk(clk), .rst(rst), .run(w_run), .prog_we(w_prog_we), .prog_addr(w_prog_addr),
    .prog_data(w_prog_data), .out_data(w_out_data), .out_valid(w_out_valid),
    .halted(w_halted), .running(w_running), .dbg_pc(w_dbg_pc)
  );

  int checks = 0;
  int errors = 0;

  // Reference machine state (persists across runs like the real core)
  logic [7:0] m_mem [16];
  logic [7:0] m_a;
  bit         m_cf, m_zf;

  logic [7:0] e_val [$];
  int         e_cyc [$];
  int         e_halt;
  logic [7:0] d_val [$];
  int         d_cyc [$];
  int         d_halt, d_stop, d_xcnt;
  bit         d_wrap;

  logic [3:0] bias_ops [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_a  = 8'h00;
    m_cf = 1'b0;
    m_zf = 1'b0;
  endtask

  task automatic load(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
    m_mem[addr] = data;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
  endtask

  // Instruction-level interpreter: edge 1 starts the first instruction,
  // an instruction costs 3/4/5 edges and its T3 effects land on its third edge.
  task automatic model_exec(input int max_cyc);
    int         t, n, s;
    logic [3:0] pc, op, arg;
    logic [7:0] w;
    e_val.delete();
    e_cyc.delete();
    e_halt = -1;
    pc = 4'd0;
    t  = 1;
    forever begin
      w   = m_mem[pc];
      op  = w[7:4];
      arg = w[3:0];
      n = (op == 4'h1 || op == 4'h4) ? 4 : (op == 4'h2 || op == 4'h3) ? 5 : 3;
      if (t + n - 1 > max_cyc) break;
      pc = pc + 4'd1;
      case (op)
        4'h1: m_a = m_mem[arg];
        4'h2: begin
          s = int'(m_a) + int'(m_mem[arg]);
          m_cf = (s > 255);
          m_a = 8'(s);
          m_zf = (m_a == 8'h00);
        end
        4'h3: begin
          s = int'(m_a) - int'(m_mem[arg]);
          m_cf = (s >= 0);
          m_a = 8'(s);
          m_zf = (m_a == 8'h00);
        end
        4'h4: m_mem[arg] = m_a;
        4'h5: m_a = {4'h0, arg};
        4'h6: pc = arg;
        4'h7: if (m_cf) pc = arg;
        4'h8: if (m_zf) pc = arg;
        4'hE: begin
          e_val.push_back(m_a);
          e_cyc.push_back(t + 2);
        end
        4'hF: begin
          e_halt = t + 2;
          break;
        end
        default: ;
      endcase
      t += n;
    end
  endtask

  // Start the core, observe max_cyc edges and compare with the interpreter.
  // disturb: prog_we+run pulse while running; sw_*: program write in the run cycle.
  task automatic run_prog(input int max_cyc, input bit disturb, input bit sw_en,
                          input logic [3:0] sw_addr, input logic [7:0] sw_data);
    logic [3:0] prev;
    if (sw_en) m_mem[sw_addr] = sw_data;
    model_exec(max_cyc);
    run       = 1'b1;
    prog_we   = sw_en;
    prog_addr = sw_addr;
    prog_data = sw_data;
    tick();
    run     = 1'b0;
    prog_we = 1'b0;
    d_val.delete();
    d_cyc.delete();
    d_halt = -1;
    d_stop = -1;
    d_xcnt = 0;
    d_wrap = 1'b0;
    prev   = dbg_pc;
    for (int c = 1; c <= max_cyc; c++) begin
      if (disturb && c == 3) begin
        run       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd14;
        prog_data = 8'h55;
      end
      tick();
      run     = 1'b0;
      prog_we = 1'b0;
      if (out_valid === 1'b1) begin
        d_val.push_back(out_data);
        d_cyc.push_back(c);
      end
      if (halted === 1'b1 && d_halt < 0) d_halt = c;
      if (running === 1'b0 && d_stop < 0) d_stop = c;
      if ($isunknown(dbg_pc)) d_xcnt++;
      if (prev == 4'd15 && dbg_pc == 4'd0) d_wrap = 1'b1;
      prev = dbg_pc;
    end
    check("n_out", d_val.size(), e_val.size());
    for (int i = 0; i < e_val.size() && i < d_val.size(); i++) begin
      check("out_val", d_val[i], e_val[i]);
      check("out_cyc", d_cyc[i], e_cyc[i]);
    end
    check("halt_cyc", d_halt, e_halt);
    check("stop_cyc", d_stop, e_halt);
    check("pc_x", d_xcnt, 0);
  endtask

  function automatic logic [31:0] first_out();
    return (d_val.size() > 0) ? 32'(d_val[0]) : 32'hDEAD;
  endfunction

  task automatic load_basic(input logic [7:0] w0);
    clear_mem();
    load(4'd0, w0);
    load(4'd1, 8'h2F);
    load(4'd2, 8'hE0);
    load(4'd3, 8'hF0);
    load(4'd14, 8'h05);
    load(4'd15, 8'h07);
  endtask

  task automatic w_load(input logic [7:0] addr, input logic [11:0] data);
    w_prog_we   = 1'b1;
    w_prog_addr = addr;
    w_prog_data = data;
    tick();
    w_prog_we   = 1'b0;
  endtask

  initial begin
    int         wv, wc, wh;
    logic [7:0] w;
    bias_ops[0] = 4'h1; bias_ops[1] = 4'h2; bias_ops[2] = 4'h3;
    bias_ops[3] = 4'h5; bias_ops[4] = 4'hE; bias_ops[5] = 4'hE;
    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    w_run = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
    m_a = 8'h00; m_cf = 1'b0; m_zf = 1'b0;
    tick();
    do_reset();

    check("rst_out_data", out_data, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_pc", dbg_pc, 4'd0);

    // Basic program: 5 + 7 = 0x0C, OUT on edge 12, halt on edge 15
    load_basic(8'h1E);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    check("basic_val", first_out(), 32'h0C);
    check("basic_n", d_val.size(), 1);
    check("basic_cyc", (d_cyc.size() > 0) ? d_cyc[0] : -1, 12);
    check("basic_halt", d_halt, 15);
    check("basic_stop", d_stop, 15);

    // Reset during ADD T4 (edge 8)
    run = 1'b1; tick(); run = 1'b0;
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    m_a = 8'h00; m_cf = 1'b0; m_zf = 1'b0;
    check("midrst_running", running, 1'b0);
    check("midrst_pc", dbg_pc, 4'd0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_out", out_data, 8'h00);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    check("rerun_val", first_out(), 32'h0C);

    // Write lands with run; prog_we/run while running are ignored
    load_basic(8'hF0);
    run_prog(40, 1'b1, 1'b1, 4'd0, 8'h1E);
    check("samecyc_val", first_out(), 32'h0C);
    check("norestart_halt", d_halt, 15);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    check("gated_we_val", first_out(), 32'h0C);

    // 3 - 5 = 0xFE, no carry, JC not taken
    clear_mem();
    load(4'd0, 8'h53); load(4'd1, 8'h3F); load(4'd2, 8'h75); load(4'd3, 8'hE0);
    load(4'd4, 8'hF0); load(4'd5, 8'h57); load(4'd6, 8'hE0); load(4'd7, 8'hF0);
    load(4'd15, 8'h05);
    run_prog(60, 1'b0, 1'b0, 4'd0, 8'd0);
    check("sub_neg_val", first_out(), 32'hFE);

    // 5 - 5 = 0, JZ 9 taken
    clear_mem();
    load(4'd0, 8'h55); load(4'd1, 8'h3F); load(4'd2, 8'h89); load(4'd3, 8'hF0);
    load(4'd9, 8'hE0); load(4'd10, 8'hF0); load(4'd15, 8'h05);
    run_prog(60, 1'b0, 1'b0, 4'd0, 8'd0);
    check("sub_zero_val", first_out(), 32'h00);

    // 0xFF + 1 overflows to zero with CF and ZF, then STA/LDA 13
    clear_mem();
    load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'h74); load(4'd3, 8'hF0);
    load(4'd4, 8'h4D); load(4'd5, 8'h59); load(4'd6, 8'h1D); load(4'd7, 8'h89);
    load(4'd8, 8'hF0); load(4'd9, 8'hE0); load(4'd10, 8'hF0);
    load(4'd13, 8'h77); load(4'd14, 8'hFF); load(4'd15, 8'h01);
    run_prog(80, 1'b0, 1'b0, 4'd0, 8'd0);
    check("ovf_val", first_out(), 32'h00);
    load(4'd0, 8'h1D); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    check("ram13_val", first_out(), 32'h00);

    // Flags survive STOP: ZF from one run steers JZ in the next
    clear_mem();
    load(4'd0, 8'h50); load(4'd1, 8'h2E); load(4'd2, 8'hF0);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    load(4'd0, 8'h84); load(4'd1, 8'hF0); load(4'd2, 8'h00);
    load(4'd4, 8'hE0); load(4'd5, 8'hF0);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    check("flag_hold_n", d_val.size(), 1);

    // PC wraps 15 -> 0
    do_reset();
    clear_mem();
    load(4'd0, 8'h83); load(4'd1, 8'h6F); load(4'd3, 8'hE0); load(4'd4, 8'hF0);
    load(4'd15, 8'h3E);
    run_prog(60, 1'b0, 1'b0, 4'd0, 8'd0);
    check("wrap_seen", d_wrap, 1'b1);
    check("wrap_val", first_out(), 32'h00);

    // Reset coincident with STA T4 (edge 7) suppresses the write
    clear_mem();
    load(4'd0, 8'h59); load(4'd1, 8'h4D); load(4'd2, 8'hF0); load(4'd13, 8'h33);
    run = 1'b1; tick(); run = 1'b0;
    repeat (6) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    m_a = 8'h00; m_cf = 1'b0; m_zf = 1'b0;
    load(4'd0, 8'h1D); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
    run_prog(40, 1'b0, 1'b0, 4'd0, 8'd0);
    check("sta_rst_val", first_out(), 32'h33);

    // Random programs
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 16; i++) begin
        w = 8'($urandom);
        if ($urandom_range(0, 1) == 1) w[7:4] = bias_ops[$urandom_range(0, 5)];
        load(4'(i), w);
      end
      run_prog(120, ($urandom_range(0, 1) == 1), 1'b0, 4'd0, 8'd0);
      if (halted !== 1'b1 || $urandom_range(0, 3) == 0) do_reset();
    end

    // Wide instance: 12-bit data, 8-bit address
    w_load(8'd0, 12'h1FE); w_load(8'd1, 12'h2FF); w_load(8'd2, 12'hE00);
    w_load(8'd3, 12'hF00); w_load(8'd254, 12'h005); w_load(8'd255, 12'h007);
    w_run = 1'b1; tick(); w_run = 1'b0;
    wv = -1; wc = -1; wh = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (w_out_valid === 1'b1 && wc < 0) begin
        wc = c;
        wv = int'(w_out_data);
      end
      if (w_halted === 1'b1 && wh < 0) wh = c;
    end
    check("wide_val", wv, 32'h00C);
    check("wide_cyc", wc, 12);
    check("wide_halt", wh, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
